// File: rtl/uart_autobaud_pkg.sv
// Shared autobaud/UART definitions: sync character, divider prescaler and detector state encoding.
package uart_autobaud_pkg;

  localparam int unsigned PRESCALER_COUNT = 8;
  localparam logic [7:0]  SYNC_CHAR       = 8'h55;
  localparam int unsigned SYNC_EDGES      = 5;

  typedef enum logic [2:0] {
    StIdle,
    StWaitIdle,
    StArmed,
    StMeasure,
    StCheckStop,
    StDone,
    StHold,
    StError
  } state_e;

endpackage

// File: rtl/uart_autobaud_if.sv
// Line and clock-divider signals shared between the autobaud detector and the UART.
interface uart_autobaud_if;
  logic        enable;
  logic        rx;
  logic        set_clock_div;
  logic [31:0] user_clock_div;
  logic        busy;
  logic        locked;
  logic        error;

  modport master (
    input  enable, rx,
    output set_clock_div, user_clock_div, busy, locked, error
  );

  modport slave (
    output enable, rx,
    input  set_clock_div, user_clock_div, busy, locked, error
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw rx line plus a falling-edge detector on the synced value.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  // [0] metastability flop, [1] synced rx, [2] previous synced rx
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], rx};
    end
  end

  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/uart_autobaud.sv
// Autobaud detector: times the falling edges of a 0x55 sync character and derives the UART divider.
// Define AUTOBAUD_RELOCK_EN to keep detecting after a lock and re-pulse on a changed divider.
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH     = 24,
  parameter int unsigned IDLE_CYCLES     = 1024,
  parameter int unsigned PRESCALER_COUNT = uart_autobaud_pkg::PRESCALER_COUNT,
  parameter int unsigned TOL_SHIFT       = 2
) (
  input logic             clk,
  input logic             rst,
  uart_autobaud_if.master bus
);
  localparam int unsigned IdleW    = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned DivShift = $clog2(8 * PRESCALER_COUNT);
  localparam logic [31:0] DivRound = 32'd1 << (DivShift - 1);

  typedef logic [COUNT_WIDTH-1:0] cnt_t;
  localparam cnt_t CntMax = '1;

  state_e               state_q, state_d;
  logic [IdleW-1:0]     idle_q, idle_d;
  cnt_t                 int_q, int_d, total_q, total_d, i1_q, i1_d;
  logic [2:0]           edge_q, edge_d;
  logic [31:0]          ucd_q, ucd_d;
  logic                 locked_q, locked_d;
  logic                 rx_s, fall;
  cnt_t                 meas, diff;
  logic                 in_tol;
  logic [COUNT_WIDTH+1:0] stop_wait;
  logic [31:0]          quot, div_val;

  uart_rx_sync u_rx_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (bus.rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  // Interval including the edge cycle itself, so four intervals sum to exactly 8 bit periods.
  assign meas      = int_q + cnt_t'(1);
  assign diff      = (meas > i1_q) ? meas - i1_q : i1_q - meas;
  assign in_tol    = diff <= (i1_q >> TOL_SHIFT);
  assign stop_wait = ({1'b0, i1_q, 1'b0} + {2'b00, i1_q}) >> 2;
  assign quot      = (32'(total_q) + DivRound) >> DivShift;
  assign div_val   = quot - 32'd1;

  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    int_d    = int_q;
    total_d  = total_q;
    i1_d     = i1_q;
    edge_d   = edge_q;
    ucd_d    = ucd_q;
    locked_d = locked_q;

    case (state_q)
      StIdle: begin
        idle_d  = '0;
        state_d = StWaitIdle;
      end
      StWaitIdle: begin
        if (!rx_s) begin
          idle_d = '0;
        end else if (idle_q == IdleW'(IDLE_CYCLES - 1)) begin
          state_d = StArmed;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
      StArmed: begin
        if (fall) begin
          total_d = '0;
          int_d   = '0;
          edge_d  = 3'd1;
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        int_d   = meas;
        total_d = total_q + cnt_t'(1);
        if (int_q == CntMax || total_q == CntMax) begin
          state_d = StError;
        end else if (fall) begin
          int_d  = '0;
          edge_d = edge_q + 3'd1;
          if (edge_q == 3'd1) begin
            i1_d = meas;
          end else if (!in_tol) begin
            state_d = StError;
          end else if (edge_q == 3'(SYNC_EDGES - 1)) begin
            state_d = StCheckStop;
          end
        end
      end
      StCheckStop: begin
        int_d = meas;
        if (int_q == CntMax) begin
          state_d = StError;
        end else if ({2'b00, int_q} >= stop_wait) begin
          if (!rx_s || quot <= 32'd1) begin
            state_d = StError;
          end else begin
`ifdef AUTOBAUD_RELOCK_EN
            if (locked_q && ucd_q == div_val) begin
              idle_d  = '0;
              state_d = StWaitIdle;
            end else begin
              ucd_d    = div_val;
              locked_d = 1'b1;
              state_d  = StDone;
            end
`else
            ucd_d    = div_val;
            locked_d = 1'b1;
            state_d  = StDone;
`endif
          end
        end
      end
      StDone: begin
`ifdef AUTOBAUD_RELOCK_EN
        idle_d  = '0;
        state_d = StWaitIdle;
`else
        state_d = StHold;
`endif
      end
      StHold: state_d = StHold;
      StError: begin
        idle_d  = '0;
        state_d = StWaitIdle;
      end
      default: state_d = StIdle;
    endcase

    // Disable overrides everything, including a lock landing in the same cycle.
    if (!bus.enable) begin
      state_d  = StIdle;
      locked_d = 1'b0;
      ucd_d    = ucd_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      idle_q   <= '0;
      int_q    <= '0;
      total_q  <= '0;
      i1_q     <= '0;
      edge_q   <= '0;
      ucd_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      int_q    <= int_d;
      total_q  <= total_d;
      i1_q     <= i1_d;
      edge_q   <= edge_d;
      ucd_q    <= ucd_d;
      locked_q <= locked_d;
    end
  end

  assign bus.set_clock_div  = (state_q == StDone);
  assign bus.error          = (state_q == StError);
  assign bus.busy           = (state_q != StIdle) && (state_q != StWaitIdle);
  assign bus.locked         = locked_q;
  assign bus.user_clock_div = ucd_q;
endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: scenario tasks checked against a bit-level line model.
module tb_uart_autobaud;
  localparam int unsigned CW   = 14;
  localparam int unsigned IDLE = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_autobaud_if bus ();

  uart_autobaud #(
    .COUNT_WIDTH (CW),
    .IDLE_CYCLES (IDLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int set_cycles = 0;
  int err_cycles = 0;
  logic [31:0] last_div = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.set_clock_div) begin
        set_cycles <= set_cycles + 1;
        last_div   <= bus.user_clock_div;
      end
      if (bus.error) err_cycles <= err_cycles + 1;
    end
  end

  // Line level at bit index idx of a frame: start, 8 data LSB-first, stop_low low bits, then idle.
  function automatic bit line_at(input logic [7:0] data, input int stop_low, input int idx);
    if (idx < 0) return 1'b1;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return data[idx-1];
    if (idx < 9 + stop_low) return 1'b0;
    return 1'b1;
  endfunction

  // outcome: 0 = lock with div, 1 = rejected, 2 = never completes (timeout)
  function automatic void model(input logic [7:0] data, input int stop_low, input int p,
                                output int outcome, output int div);
    int e[$];
    int i1, ik, total, samp;
    div = 0;
    for (int idx = 0; idx <= 9 + stop_low; idx++)
      if (line_at(data, stop_low, idx - 1) && !line_at(data, stop_low, idx)) e.push_back(idx * p);
    if (e.size() < 2) begin outcome = 2; return; end
    i1 = e[1] - e[0];
    for (int k = 2; k <= 4; k++) begin
      if (k >= e.size()) begin outcome = 2; return; end
      ik = e[k] - e[k-1];
      if ((ik > i1 ? ik - i1 : i1 - ik) > i1 / 4) begin outcome = 1; return; end
    end
    total = e[4] - e[0];
    samp  = (e[4] + (3 * i1) / 4) / p;
    if (!line_at(data, stop_low, samp)) begin outcome = 1; return; end
    div = (total + 32) / 64 - 1;
    outcome = (div <= 0) ? 1 : 0;
  endfunction

  task automatic send_frame(input logic [7:0] data, input int p, input int stop_low);
    bus.rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = data[i];
      repeat (p) @(negedge clk);
    end
    if (stop_low > 0) begin
      bus.rx = 1'b0;
      repeat (stop_low * p) @(negedge clk);
    end
    bus.rx = 1'b1;
  endtask

  task automatic new_session();
    @(negedge clk);
    bus.enable = 1'b0;
    bus.rx     = 1'b1;
    repeat (2) @(negedge clk);
    bus.enable = 1'b1;
    repeat (IDLE + 30) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.enable = 1'b0;
    bus.rx     = 1'b1;
    rst        = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.set_clock_div !== 1'b0) begin failures++; $display("FAIL reset_set: got %b want 0", bus.set_clock_div); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
    if (bus.error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", bus.error); end
    if (bus.user_clock_div !== 32'd0) begin failures++; $display("FAIL reset_div: got %0d want 0", bus.user_clock_div); end
    rst = 1'b1;
  endtask

  task automatic test_lock_rate(input int p);
    int out, d, s0, e0;
    new_session();
    model(8'h55, 0, p, out, d);
    s0 = set_cycles; e0 = err_cycles;
    send_frame(8'h55, p, 0);
    repeat (p + 20) @(negedge clk);
    checks += 4;
    if (set_cycles - s0 !== 1) begin failures++; $display("FAIL lock_pulse p=%0d: got %0d cycles want 1", p, set_cycles - s0); end
    if (last_div !== 32'(d)) begin failures++; $display("FAIL lock_div p=%0d: got %0d want %0d", p, last_div, d); end
    if (bus.locked !== 1'b1) begin failures++; $display("FAIL lock_locked p=%0d: got %b want 1", p, bus.locked); end
    if (err_cycles !== e0) begin failures++; $display("FAIL lock_noerr p=%0d: got %0d errors want 0", p, err_cycles - e0); end
  endtask

  // Follows a 434-cycle lock; covers HOLD (default) or relock behaviour.
  task automatic test_after_lock();
    int out, d, s0;
    logic [31:0] held;
    held = bus.user_clock_div;
    s0 = set_cycles;
    model(8'h55, 0, 217, out, d);
`ifdef AUTOBAUD_RELOCK_EN
    repeat (IDLE + 30) @(negedge clk);
    send_frame(8'h55, 217, 0);
    repeat (240) @(negedge clk);
    checks += 2;
    if (set_cycles - s0 !== 1) begin failures++; $display("FAIL relock_pulse: got %0d want 1", set_cycles - s0); end
    if (bus.user_clock_div !== 32'(d)) begin failures++; $display("FAIL relock_div: got %0d want %0d", bus.user_clock_div, d); end
    repeat (IDLE + 30) @(negedge clk);
    send_frame(8'h55, 217, 0);
    repeat (240) @(negedge clk);
    checks++;
    if (set_cycles - s0 !== 1) begin failures++; $display("FAIL relock_same: got %0d pulses want 1", set_cycles - s0); end
    held = bus.user_clock_div;
`else
    send_frame(8'h55, 217, 0);
    repeat (240) @(negedge clk);
    checks += 2;
    if (set_cycles !== s0) begin failures++; $display("FAIL hold_nopulse: got %0d want 0", set_cycles - s0); end
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL hold_busy: got %b want 1", bus.busy); end
`endif
    bus.enable = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.locked !== 1'b0) begin failures++; $display("FAIL disable_locked: got %b want 0", bus.locked); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL disable_busy: got %b want 0", bus.busy); end
    if (bus.user_clock_div !== held) begin failures++; $display("FAIL disable_div: got %0d want %0d", bus.user_clock_div, held); end
  endtask

  task automatic test_bad_char();
    int out, d, s0, e0;
    new_session();
    model(8'h41, 0, 434, out, d);
    s0 = set_cycles; e0 = err_cycles;
    send_frame(8'h41, 434, 0);
    repeat (454) @(negedge clk);
    checks += 3;
    if (err_cycles - e0 !== (out == 1 ? 1 : 0)) begin failures++; $display("FAIL badchar_err: got %0d want 1", err_cycles - e0); end
    if (set_cycles !== s0) begin failures++; $display("FAIL badchar_nopulse: got %0d want 0", set_cycles - s0); end
    if (bus.locked !== 1'b0) begin failures++; $display("FAIL badchar_locked: got %b want 0", bus.locked); end
    repeat (IDLE + 30) @(negedge clk);
    model(8'h55, 0, 434, out, d);
    send_frame(8'h55, 434, 0);
    repeat (454) @(negedge clk);
    checks += 2;
    if (set_cycles - s0 !== 1) begin failures++; $display("FAIL badchar_relock: got %0d want 1", set_cycles - s0); end
    if (last_div !== 32'(d)) begin failures++; $display("FAIL badchar_div: got %0d want %0d", last_div, d); end
  endtask

  task automatic test_framing();
    int out, d, s0, e0;
    new_session();
    model(8'h55, 2, 434, out, d);
    s0 = set_cycles; e0 = err_cycles;
    send_frame(8'h55, 434, 2);
    repeat (1000) @(negedge clk);
    checks += 3;
    if (err_cycles - e0 !== (out == 1 ? 1 : 0)) begin failures++; $display("FAIL framing_err: got %0d want 1", err_cycles - e0); end
    if (set_cycles !== s0) begin failures++; $display("FAIL framing_nopulse: got %0d want 0", set_cycles - s0); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL framing_early_arm: got %b want 0", bus.busy); end
    repeat (60) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL framing_rearm: got %b want 1", bus.busy); end
  endtask

  task automatic test_timeout();
    int e0, s0, n;
    new_session();
    e0 = err_cycles; s0 = set_cycles; n = 0;
    bus.rx = 1'b0;
    while (err_cycles == e0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    checks += 3;
    if (err_cycles - e0 !== 1) begin failures++; $display("FAIL timeout_err: got %0d want 1", err_cycles - e0); end
    if (n < (1 << CW) - 8) begin failures++; $display("FAIL timeout_early: got %0d cycles want >= %0d", n, (1 << CW) - 8); end
    if (set_cycles !== s0) begin failures++; $display("FAIL timeout_nopulse: got %0d want 0", set_cycles - s0); end
  endtask

  task automatic test_enable_drop();
    int e0, s0;
    new_session();
    e0 = err_cycles; s0 = set_cycles;
    bus.rx = 1'b0; repeat (60) @(negedge clk);
    bus.rx = 1'b1; repeat (60) @(negedge clk);
    bus.rx = 1'b0; repeat (10) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL drop_measuring: got %b want 1", bus.busy); end
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL drop_idle: got %b want 0", bus.busy); end
    bus.rx = 1'b1;
    repeat (300) @(negedge clk);
    checks += 2;
    if (err_cycles !== e0) begin failures++; $display("FAIL drop_noerr: got %0d want 0", err_cycles - e0); end
    if (set_cycles !== s0) begin failures++; $display("FAIL drop_nopulse: got %0d want 0", set_cycles - s0); end
  endtask

  task automatic test_random();
    int out, d, s0, e0, p, stop_low;
    logic [7:0] data;
    for (int it = 0; it < 4; it++) begin
      p = $urandom_range(200, 40);
      data = ($urandom_range(1, 0) == 1) ? 8'h55 : 8'($urandom);
      stop_low = ($urandom_range(3, 0) == 0) ? 1 : 0;
      model(data, stop_low, p, out, d);
      if (out == 2) begin
        data = 8'h55;
        model(data, stop_low, p, out, d);
      end
      new_session();
      s0 = set_cycles; e0 = err_cycles;
      send_frame(data, p, stop_low);
      repeat (p + 20) @(negedge clk);
      checks += 3;
      if (set_cycles - s0 !== (out == 0 ? 1 : 0))
        begin failures++; $display("FAIL rand_pulse data=%h p=%0d: got %0d want %0d", data, p, set_cycles - s0, out == 0); end
      if (err_cycles - e0 !== (out == 1 ? 1 : 0))
        begin failures++; $display("FAIL rand_err data=%h p=%0d: got %0d want %0d", data, p, err_cycles - e0, out == 1); end
      if (bus.locked !== (out == 0))
        begin failures++; $display("FAIL rand_locked data=%h p=%0d: got %b want %b", data, p, bus.locked, out == 0); end
      if (out == 0) begin
        checks++;
        if (bus.user_clock_div !== 32'(d))
          begin failures++; $display("FAIL rand_div data=%h p=%0d: got %0d want %0d", data, p, bus.user_clock_div, d); end
      end
    end
  endtask

  task automatic test_reset_mid();
    new_session();
    bus.rx = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    if (bus.user_clock_div !== 32'd0) begin failures++; $display("FAIL rstmid_div: got %0d want 0", bus.user_clock_div); end
    if (bus.locked !== 1'b0) begin failures++; $display("FAIL rstmid_locked: got %b want 0", bus.locked); end
    bus.rx = 1'b1;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_rate(434);
    test_after_lock();
    test_lock_rate(1200);
    test_bad_char();
    test_framing();
    test_timeout();
    test_enable_drop();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
